// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared constants for the ATM account back-end
package atm_pkg;

   localparam int NUM_ACCOUNTS = 10;
   localparam int INIT_BALANCE = 500;
   localparam int BAL_W        = 32;
   localparam int PIN_W        = 16;
   localparam int ACC_W        = 4;
   localparam int OP_W         = 3;
   localparam int ST_W         = 3;

   localparam logic [PIN_W-1:0] PIN_BASE = 16'h1230;

   localparam logic [OP_W-1:0] OP_BALANCE    = 3'd1;
   localparam logic [OP_W-1:0] OP_WITHDRAW   = 3'd2;
   localparam logic [OP_W-1:0] OP_DEPOSIT    = 3'd3;
   localparam logic [OP_W-1:0] OP_CHANGE_PIN = 3'd4;
   localparam logic [OP_W-1:0] OP_EXIT       = 3'd5;

   localparam logic [ST_W-1:0] ST_OK           = 3'd0;
   localparam logic [ST_W-1:0] ST_NOT_FOUND    = 3'd1;
   localparam logic [ST_W-1:0] ST_BAD_PIN      = 3'd2;
   localparam logic [ST_W-1:0] ST_INSUFFICIENT = 3'd3;
   localparam logic [ST_W-1:0] ST_OVERFLOW     = 3'd4;
   localparam logic [ST_W-1:0] ST_BAD_OP       = 3'd5;
   localparam logic [ST_W-1:0] ST_LOCKED       = 3'd6;

endpackage

// File: rtl/atm_authenticator.sv
// rtl/atm_authenticator.sv - account lookup, PIN compare and optional lockout (ATM_LOCKOUT_EN)
module atm_authenticator
   import atm_pkg::*;
#(
`ifdef ATM_LOCKOUT_EN
   parameter int NUM_ACCOUNTS = atm_pkg::NUM_ACCOUNTS,
   parameter int MAX_FAILS    = 3
`else
   parameter int NUM_ACCOUNTS = atm_pkg::NUM_ACCOUNTS
`endif
) (
`ifdef ATM_LOCKOUT_EN
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
`endif
   input  logic [ACC_W-1:0] acc_num,
   input  logic [PIN_W-1:0] pin,
   input  logic [PIN_W-1:0] pin_store [NUM_ACCOUNTS],
   output logic [ACC_W-1:0] acc_index,
   output logic             acc_found,
   output logic             acc_locked,
   output logic             acc_auth
);

   logic pin_match;

   // Index is forced to 0 for unknown accounts so the store is never read out of range
   always_comb begin
      acc_found = (int'(acc_num) < NUM_ACCOUNTS);
      acc_index = acc_found ? acc_num : '0;
      pin_match = acc_found && (pin == pin_store[acc_index]);
      acc_auth  = pin_match && !acc_locked;
   end

`ifdef ATM_LOCKOUT_EN
   localparam int CNT_W = $clog2(MAX_FAILS + 1);

   logic [CNT_W-1:0] fail_cnt [NUM_ACCOUNTS];

   assign acc_locked = acc_found && (fail_cnt[acc_index] == CNT_W'(MAX_FAILS));

   // Consecutive bad-PIN counters; a locked account stays locked until reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ACCOUNTS; i++) fail_cnt[i] <= '0;
      end else if (op_valid && acc_found && !acc_locked) begin
         if (pin_match) fail_cnt[acc_index] <= '0;
         else           fail_cnt[acc_index] <= fail_cnt[acc_index] + 1'b1;
      end
   end
`else
   assign acc_locked = 1'b0;
`endif

endmodule

// File: rtl/atm_auth_functions.sv
// rtl/atm_auth_functions.sv - account store and transaction datapath; lockout via ATM_LOCKOUT_EN
module atm_auth_functions
   import atm_pkg::*;
#(
   parameter int NUM_ACCOUNTS = atm_pkg::NUM_ACCOUNTS,
   parameter int INIT_BALANCE = atm_pkg::INIT_BALANCE,
   parameter int MAX_FAILS    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [OP_W-1:0]  operation,
   input  logic [ACC_W-1:0] acc_num,
   input  logic [PIN_W-1:0] pin,
   input  logic [PIN_W-1:0] new_pin,
   input  logic [BAL_W-1:0] amount,
   output logic [ACC_W-1:0] acc_index,
   output logic             acc_found,
   output logic             acc_auth,
   output logic             done,
   output logic [ST_W-1:0]  status,
   output logic [BAL_W-1:0] balance
);

   logic [BAL_W-1:0] bal_store [NUM_ACCOUNTS];
   logic [PIN_W-1:0] pin_store [NUM_ACCOUNTS];

   logic             acc_locked;
   logic [BAL_W-1:0] cur_bal;
   logic [BAL_W:0]   dep_sum;
   logic [ST_W-1:0]  res_status;
   logic [BAL_W-1:0] res_balance;
   logic             bal_we;
   logic [BAL_W-1:0] bal_next;
   logic             pin_we;

   atm_authenticator #(
`ifdef ATM_LOCKOUT_EN
      .NUM_ACCOUNTS (NUM_ACCOUNTS),
      .MAX_FAILS    (MAX_FAILS)
`else
      .NUM_ACCOUNTS (NUM_ACCOUNTS)
`endif
   ) u_auth (
`ifdef ATM_LOCKOUT_EN
      .clk        (clk),
      .rst        (rst),
      .op_valid   (op_valid),
`endif
      .acc_num    (acc_num),
      .pin        (pin),
      .pin_store  (pin_store),
      .acc_index  (acc_index),
      .acc_found  (acc_found),
      .acc_locked (acc_locked),
      .acc_auth   (acc_auth)
   );

   // Outcome of the presented request, checked in priority order
   always_comb begin
      cur_bal     = bal_store[acc_index];
      dep_sum     = {1'b0, cur_bal} + {1'b0, amount};
      res_status  = ST_OK;
      res_balance = '0;
      bal_we      = 1'b0;
      bal_next    = cur_bal;
      pin_we      = 1'b0;
      if (!acc_found) begin
         res_status = ST_NOT_FOUND;
      end else if (acc_locked) begin
         res_status = ST_LOCKED;
      end else if (!acc_auth) begin
         res_status = ST_BAD_PIN;
      end else begin
         case (operation)
            OP_BALANCE: res_balance = cur_bal;
            OP_WITHDRAW: begin
               if (amount > cur_bal) begin
                  res_status  = ST_INSUFFICIENT;
                  res_balance = cur_bal;
               end else begin
                  bal_we      = 1'b1;
                  bal_next    = cur_bal - amount;
                  res_balance = cur_bal - amount;
               end
            end
            OP_DEPOSIT: begin
               if (dep_sum[BAL_W]) begin
                  res_status = ST_OVERFLOW;
               end else begin
                  bal_we      = 1'b1;
                  bal_next    = dep_sum[BAL_W-1:0];
                  res_balance = dep_sum[BAL_W-1:0];
               end
            end
            OP_CHANGE_PIN: begin
               pin_we      = 1'b1;
               res_balance = cur_bal;
            end
            OP_EXIT: res_balance = '0;
            default: res_status = ST_BAD_OP;
         endcase
      end
   end

   // Stores and result registers; only the addressed account is written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            bal_store[i] <= BAL_W'(INIT_BALANCE);
            pin_store[i] <= PIN_BASE + PIN_W'(i);
         end
         done    <= 1'b0;
         status  <= ST_OK;
         balance <= '0;
      end else begin
         done <= op_valid;
         if (op_valid) begin
            status  <= res_status;
            balance <= res_balance;
            if (bal_we) bal_store[acc_index] <= bal_next;
            if (pin_we) pin_store[acc_index] <= new_pin;
         end
      end
   end

endmodule

// File: tb/tb_atm_auth_functions.sv
// tb/tb_atm_auth_functions.sv - scoreboard bench for atm_auth_functions (ATM_LOCKOUT_EN aware)
module tb_atm_auth_functions;

   localparam int N  = 10;
   localparam int MF = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_valid = 1'b0;
   logic [2:0]  operation = '0;
   logic [3:0]  acc_num = '0;
   logic [15:0] pin = '0;
   logic [15:0] new_pin = '0;
   logic [31:0] amount = '0;
   logic [3:0]  acc_index;
   logic        acc_found;
   logic        acc_auth;
   logic        done;
   logic [2:0]  status;
   logic [31:0] balance;

   int checks = 0;
   int errors = 0;

   logic [31:0] mbal  [N];
   logic [15:0] mpin  [N];
   int          mfail [N];
   logic [2:0]  q_st  [$];
   logic [31:0] q_bal [$];
   logic        exp_done;

   atm_auth_functions #(.NUM_ACCOUNTS(N), .INIT_BALANCE(500), .MAX_FAILS(MF)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .operation(operation),
      .acc_num(acc_num), .pin(pin), .new_pin(new_pin), .amount(amount),
      .acc_index(acc_index), .acc_found(acc_found), .acc_auth(acc_auth),
      .done(done), .status(status), .balance(balance)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         mbal[i]  = 32'd500;
         mpin[i]  = 16'h1230 + 16'(i);
         mfail[i] = 0;
      end
   endfunction

   function automatic bit m_locked(input int a);
`ifdef ATM_LOCKOUT_EN
      return a < N && mfail[a] >= MF;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit m_auth(input int a, input logic [15:0] p);
      return a < N && p == mpin[a] && !m_locked(a);
   endfunction

   // Reference behaviour of one accepted request; updates the model store
   function automatic void model_op(input logic [2:0] op, input int a, input logic [15:0] p,
                                    input logic [15:0] np, input logic [31:0] amt,
                                    output logic [2:0] st, output logic [31:0] b);
      longint sum;
      st = 3'd0;
      b  = 32'd0;
      if (a >= N) begin
         st = 3'd1;
      end else if (m_locked(a)) begin
         st = 3'd6;
      end else if (p != mpin[a]) begin
         st = 3'd2;
         mfail[a] = mfail[a] + 1;
      end else begin
         mfail[a] = 0;
         case (op)
            3'd1: b = mbal[a];
            3'd2: if (amt > mbal[a]) begin st = 3'd3; b = mbal[a]; end
                  else begin mbal[a] = mbal[a] - amt; b = mbal[a]; end
            3'd3: begin
               sum = longint'(mbal[a]) + longint'(amt);
               if (sum > 64'hFFFF_FFFF) st = 3'd4;
               else begin mbal[a] = 32'(sum); b = mbal[a]; end
            end
            3'd4: begin mpin[a] = np; b = mbal[a]; end
            3'd5: b = 32'd0;
            default: st = 3'd5;
         endcase
      end
   endfunction

   task automatic do_op(input logic [2:0] op, input int a, input logic [15:0] p,
                        input logic [15:0] np, input logic [31:0] amt);
      logic [2:0]  st;
      logic [31:0] b;
      bit          f;
      @(negedge clk);
      operation = op; acc_num = 4'(a); pin = p; new_pin = np; amount = amt;
      op_valid  = 1'b1;
      f = a < N;
      #1;
      check("acc_found", 32'(acc_found), 32'(f));
      check("acc_index", 32'(acc_index), f ? 32'(a) : 32'd0);
      check("acc_auth",  32'(acc_auth),  32'(m_auth(a, p)));
      model_op(op, a, p, np, amt, st, b);
      q_st.push_back(st);
      q_bal.push_back(b);
      @(posedge clk);
      #1 op_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         op_valid  = 1'b0;
         operation = 3'($urandom);
         acc_num   = 4'($urandom);
         pin       = 16'($urandom);
         new_pin   = 16'($urandom);
         amount    = $urandom;
      end
   endtask

   // Expected done follows op_valid sampled at the previous edge
   always @(posedge clk or posedge rst) begin
      if (rst) exp_done <= 1'b0;
      else     exp_done <= op_valid;
   end

   // Monitor: pops the scoreboard whenever the DUT presents a result
   always @(negedge clk) begin
      if (!rst) begin
         check("done", 32'(done), 32'(exp_done));
         if (done) begin
            if (q_st.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               check("status",  32'(status), 32'(q_st.pop_front()));
               check("balance", balance, q_bal.pop_front());
            end
         end
      end
   end

   initial begin
      int a;
      logic [2:0] op;
      logic [15:0] p;
      logic [31:0] amt;
      model_reset();
      #12;
      check("rst_done", 32'(done), 32'd0);
      check("rst_status", 32'(status), 32'd0);
      check("rst_balance", balance, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(3'd1, 3, 16'h1233, 16'h0, 32'd0);
      do_op(3'd2, 0, 16'h1230, 16'h0, 32'd200);
      do_op(3'd2, 0, 16'h1230, 16'h0, 32'd400);
      do_op(3'd3, 1, 16'h1231, 16'h0, 32'hFFFF_FFFF);
      do_op(3'd3, 1, 16'h1231, 16'h0, 32'd100);
      do_op(3'd3, 1, 16'h1231, 16'h0, 32'd0);
      do_op(3'd4, 2, 16'h1232, 16'h9999, 32'd0);
      do_op(3'd1, 2, 16'h1232, 16'h0, 32'd0);
      do_op(3'd1, 2, 16'h9999, 16'h0, 32'd0);
      do_op(3'd1, 12, 16'h1232, 16'h0, 32'd0);
      do_op(3'd7, 5, 16'h1235, 16'h0, 32'd0);
      do_op(3'd0, 5, 16'h1235, 16'h0, 32'd0);
      do_op(3'd5, 6, 16'h1236, 16'h0, 32'd0);
      do_op(3'd2, 6, 16'h1236, 16'h0, 32'd500);
      idle(2);
      for (int i = 0; i < 3; i++) do_op(3'd1, 4, 16'h0000, 16'h0, 32'd0);
      do_op(3'd1, 4, 16'h1234, 16'h0, 32'd0);
      idle(2);

      // Reset during a pending request: result aborted, state restored at once
      @(negedge clk);
      operation = 3'd2; acc_num = 4'd0; pin = 16'h1230; amount = 32'd50; op_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("arst_done", 32'(done), 32'd0);
      check("arst_status", 32'(status), 32'd0);
      check("arst_balance", balance, 32'd0);
      pin = 16'h1232; acc_num = 4'd2;
      #1;
      check("arst_pin_restored", 32'(acc_auth), 32'd1);
      model_reset();
      @(posedge clk);
      #1;
      check("arst_done_edge", 32'(done), 32'd0);
      op_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      do_op(3'd1, 0, 16'h1230, 16'h0, 32'd0);
      do_op(3'd1, 4, 16'h1234, 16'h0, 32'd0);

      for (int i = 0; i < 300; i++) begin
         a   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         op  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(1, 5));
         p   = ($urandom_range(0, 5) == 0 || a >= N) ? 16'($urandom) : mpin[a];
         case ($urandom_range(0, 3))
            0: amt = 32'($urandom_range(0, 1000));
            1: amt = (a < N) ? mbal[a] : 32'd0;
            2: amt = $urandom;
            default: amt = 32'($urandom_range(0, 100));
         endcase
         do_op(op, a, p, 16'($urandom), amt);
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end

      for (int i = 0; i < 10 && q_st.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 32'(q_st.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
